pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: PC and address width.
REQ-002 Parameter RESET_VECTOR, default 32'h00000000: PC value loaded on reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h00000100: PC value loaded on trap or misaligned redirect.
REQ-004 Parameter RAS_DEPTH, default 4, power of two >= 2: return-address-stack entries.
REQ-005 clk  in  1  the one clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 pc_write_enable  in  1  0 = fetch stall; holds the sequential and return-prediction PC update.
REQ-008 trap_valid  in  1  trap request.
REQ-009 ex_redirect_valid  in  1  EX-stage branch or jump resolved taken.
REQ-010 ex_redirect_target  in  XLEN  EX redirect address.
REQ-011 id_call  in  1  ID holds a call; push id_link_addr.
REQ-012 id_link_addr  in  XLEN  return address to push.
REQ-013 id_ret  in  1  ID holds a return; redirect to the RAS top.
REQ-014 pc_out  out  XLEN  current fetch PC (registered).
REQ-015 flush_out  out  1  registered one-cycle pulse: pc_out took a non-sequential value this cycle.
REQ-016 misaligned_out  out  1  registered one-cycle pulse: the last EX redirect target was misaligned.
REQ-017 ras_empty  out  1  RAS holds zero valid entries.

Function
REQ-018 Next-PC priority: trap_valid > ex_redirect_valid > id_ret with RAS non-empty > pc_out + 4.
REQ-019 Trap: next PC = TRAP_VECTOR, applied regardless of pc_write_enable.
REQ-020 EX redirect with target[1:0] == 0: next PC = ex_redirect_target, applied regardless of pc_write_enable.
REQ-021 EX redirect with target[1:0] != 0: next PC = TRAP_VECTOR; misaligned_out = 1 the following cycle.
REQ-022 id_ret with RAS non-empty and pc_write_enable = 1, and no trap or EX redirect: next PC = RAS top; pop one entry.
REQ-023 id_ret with RAS empty: ignored; sequential update applies; RAS unchanged.
REQ-024 Sequential: when pc_write_enable = 1 and no higher source applies, next PC = pc_out + 4, modulo 2^XLEN (wraps to 0).
REQ-025 No source active and pc_write_enable = 0: pc_out holds.
REQ-026 flush_out = 1 in the cycle after any trap, EX redirect, or applied RAS return; 0 otherwise.
REQ-027 RAS push and pop are enabled only when pc_write_enable = 1 and trap_valid = 0 and ex_redirect_valid = 0; otherwise the RAS is unchanged.
REQ-028 Push: id_link_addr written to top+1; count = min(count+1, RAS_DEPTH).
REQ-029 Push on full RAS: circular overwrite of the oldest entry; count stays RAS_DEPTH.
REQ-030 Simultaneous push and applied pop (id_call and id_ret): redirect uses the old top; top entry is replaced by id_link_addr; count unchanged.
REQ-031 Pop on empty never decrements count below 0.
REQ-032 ras_empty = (count == 0), derived from registered state.
REQ-033 Latency: every PC update is visible on pc_out one cycle after the request; no combinational path from inputs to outputs.

Reset
REQ-034 rst = 1 at a rising edge: pc_out = RESET_VECTOR; flush_out = 0; misaligned_out = 0; RAS count = 0; ras_empty = 1.
REQ-035 Reset overrides all other inputs, including trap and redirect in the same cycle.
REQ-036 RAS entry contents need no reset.

Verification
REQ-037 Reset, then 3 cycles with pc_write_enable = 1 -> pc_out 0x0, 0x4, 0x8, 0xC; flush_out = 0 throughout.
REQ-038 ex_redirect_valid = 1, target 0x200, with pc_write_enable = 0 -> pc_out = 0x200 next cycle; flush_out pulses for 1 cycle.
REQ-039 trap_valid and ex_redirect_valid together (target 0x300) -> pc_out = 0x100; flush_out = 1.
REQ-040 Target 0x202 -> pc_out = 0x100; misaligned_out = 1 for exactly one cycle.
REQ-041 Push 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH = 4; then 5 id_ret -> returns 0x50, 0x40, 0x30, 0x20; the 5th id_ret falls through to pc + 4; ras_empty = 1.
REQ-042 pc_out = 0xFFFFFFFC with pc_write_enable = 1 -> pc_out = 0x0; rst asserted during an EX redirect -> pc_out = RESET_VECTOR and ras_empty = 1.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch PC generator: next-PC selection (trap, EX redirect, RAS return,
// sequential) plus a small circular return-address stack.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write_enable,
    input  logic            trap_valid,
    input  logic            ex_redirect_valid,
    input  logic [XLEN-1:0] ex_redirect_target,
    input  logic            id_call,
    input  logic [XLEN-1:0] id_link_addr,
    input  logic            id_ret,
    output logic [XLEN-1:0] pc_out,
    output logic            flush_out,
    output logic            misaligned_out,
    output logic            ras_empty
);

    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_top;
    logic [CW-1:0]   ras_count;

    logic            ras_ok;
    logic            do_push;
    logic            do_pop;
    logic [XLEN-1:0] pc_next;
    logic            flush_next;
    logic            misaligned_next;

    // Next-PC priority mux and RAS push/pop qualification
    always_comb begin
        ras_ok          = pc_write_enable && !trap_valid && !ex_redirect_valid;
        do_pop          = ras_ok && id_ret && (ras_count != '0);
        do_push         = ras_ok && id_call;
        pc_next         = pc_out;
        flush_next      = 1'b0;
        misaligned_next = 1'b0;
        if (trap_valid) begin
            pc_next    = TRAP_VECTOR;
            flush_next = 1'b1;
        end else if (ex_redirect_valid) begin
            flush_next = 1'b1;
            if (ex_redirect_target[1:0] != 2'b00) begin
                pc_next         = TRAP_VECTOR;
                misaligned_next = 1'b1;
            end else begin
                pc_next = ex_redirect_target;
            end
        end else if (do_pop) begin
            pc_next    = ras_mem[ras_top];
            flush_next = 1'b1;
        end else if (pc_write_enable) begin
            pc_next = pc_out + XLEN'(4);
        end
    end

    // PC and status pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out         <= RESET_VECTOR;
            flush_out      <= 1'b0;
            misaligned_out <= 1'b0;
        end else begin
            pc_out         <= pc_next;
            flush_out      <= flush_next;
            misaligned_out <= misaligned_next;
        end
    end

    // RAS pointer and occupancy; a push on a full stack overwrites the oldest
    // entry because the top pointer simply wraps around the array
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_top   <= '0;
            ras_count <= '0;
        end else if (do_push && do_pop) begin
            ras_top   <= ras_top;
            ras_count <= ras_count;
        end else if (do_push) begin
            ras_top <= ras_top + PW'(1);
            if (ras_count != CW'(RAS_DEPTH)) begin
                ras_count <= ras_count + CW'(1);
            end
        end else if (do_pop) begin
            ras_top   <= ras_top - PW'(1);
            ras_count <= ras_count - CW'(1);
        end
    end

    // RAS storage; a simultaneous call/return replaces the top in place
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            if (do_pop) begin
                ras_mem[ras_top] <= id_link_addr;
            end else begin
                ras_mem[ras_top + PW'(1)] <= id_link_addr;
            end
        end
    end

    assign ras_empty = (ras_count == '0);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_pc_gen;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write_enable = 1'b0;
    logic        trap_valid = 1'b0;
    logic        ex_redirect_valid = 1'b0;
    logic [31:0] ex_redirect_target = '0;
    logic        id_call = 1'b0;
    logic [31:0] id_link_addr = '0;
    logic        id_ret = 1'b0;
    logic [31:0] pc_out;
    logic        flush_out;
    logic        misaligned_out;
    logic        ras_empty;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // reference model state
    logic [31:0] m_pc = RV;
    logic        m_flush = 1'b0;
    logic        m_mis = 1'b0;
    logic [31:0] m_ras[$];

    pc_gen #(
        .XLEN(XLEN),
        .RESET_VECTOR(RV),
        .TRAP_VECTOR(TV),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc_write_enable(pc_write_enable),
        .trap_valid(trap_valid),
        .ex_redirect_valid(ex_redirect_valid),
        .ex_redirect_target(ex_redirect_target),
        .id_call(id_call),
        .id_link_addr(id_link_addr),
        .id_ret(id_ret),
        .pc_out(pc_out),
        .flush_out(flush_out),
        .misaligned_out(misaligned_out),
        .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it, advance the model, settle 1 time unit
    task automatic cycle(input bit r, input bit we, input bit tr, input bit exv,
                         input logic [31:0] tgt, input bit call,
                         input logic [31:0] link, input bit ret);
        bit ok;
        rst = r; pc_write_enable = we; trap_valid = tr; ex_redirect_valid = exv;
        ex_redirect_target = tgt; id_call = call; id_link_addr = link; id_ret = ret;
        @(posedge clk);
        if (r) begin
            m_pc = RV; m_flush = 0; m_mis = 0; m_ras.delete();
        end else if (tr) begin
            m_pc = TV; m_flush = 1; m_mis = 0;
        end else if (exv) begin
            m_flush = 1;
            m_mis = (tgt % 4) != 0;
            m_pc = m_mis ? TV : tgt;
        end else begin
            m_mis = 0;
            m_flush = 0;
            if (we && ret && m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
                m_flush = 1;
            end else if (we) begin
                m_pc = m_pc + 32'd4;
            end
            if (we && call) begin
                m_ras.push_back(link);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
        end
        ok = 1;
        #1;
    endtask

    task automatic idle(input bit we);
        cycle(0, we, 0, 0, '0, 0, '0, 0);
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 1, 32'h300, 1, 32'h44, 1);
        cycle(1, 0, 0, 0, '0, 0, '0, 0);
        vectors++;
        if ({pc_out, flush_out, misaligned_out, ras_empty} !== {RV, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset: pc=%h flush=%b mis=%b empty=%b, want pc=%h 0 0 1",
                     pc_out, flush_out, misaligned_out, ras_empty, RV);
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            vectors++;
            if (pc_out !== 32'(4 * i) || flush_out !== 1'b0) begin
                miscompares++;
                $display("FAIL sequential[%0d]: pc=%h flush=%b, want pc=%h flush=0",
                         i, pc_out, flush_out, 32'(4 * i));
            end
        end
        idle(0);
        vectors++;
        if (pc_out !== 32'hC || flush_out !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold: pc=%h flush=%b, want pc=0000000c flush=0", pc_out, flush_out);
        end
    endtask

    task automatic test_redirect();
        cycle(0, 0, 0, 1, 32'h200, 0, '0, 0);
        vectors++;
        if (pc_out !== 32'h200 || flush_out !== 1'b1 || misaligned_out !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect: pc=%h flush=%b mis=%b, want pc=00000200 1 0",
                     pc_out, flush_out, misaligned_out);
        end
        idle(0);
        vectors++;
        if (pc_out !== 32'h200 || flush_out !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_pulse: pc=%h flush=%b, want pc=00000200 flush=0", pc_out, flush_out);
        end
    endtask

    task automatic test_trap_priority();
        cycle(0, 1, 1, 1, 32'h300, 0, '0, 0);
        vectors++;
        if (pc_out !== TV || flush_out !== 1'b1 || misaligned_out !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_priority: pc=%h flush=%b mis=%b, want pc=%h 1 0",
                     pc_out, flush_out, misaligned_out, TV);
        end
    endtask

    task automatic test_misaligned();
        cycle(0, 1, 0, 1, 32'h202, 0, '0, 0);
        vectors++;
        if (pc_out !== TV || misaligned_out !== 1'b1 || flush_out !== 1'b1) begin
            miscompares++;
            $display("FAIL misaligned: pc=%h mis=%b flush=%b, want pc=%h 1 1",
                     pc_out, misaligned_out, flush_out, TV);
        end
        idle(0);
        vectors++;
        if (misaligned_out !== 1'b0 || pc_out !== TV) begin
            miscompares++;
            $display("FAIL misaligned_pulse: mis=%b pc=%h, want mis=0 pc=%h", misaligned_out, pc_out, TV);
        end
    endtask

    task automatic test_ras();
        logic [31:0] exp_ret;
        logic [31:0] last;
        for (int i = 1; i <= 5; i++) cycle(0, 1, 0, 0, '0, 1, 32'(16 * i), 0);
        vectors++;
        if (ras_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL ras_fill: ras_empty=%b, want 0", ras_empty);
        end
        for (int i = 0; i < 4; i++) begin
            exp_ret = 32'h50 - 32'(16 * i);
            cycle(0, 1, 0, 0, '0, 0, '0, 1);
            vectors++;
            if (pc_out !== exp_ret || flush_out !== 1'b1) begin
                miscompares++;
                $display("FAIL ras_return[%0d]: pc=%h flush=%b, want pc=%h flush=1",
                         i, pc_out, flush_out, exp_ret);
            end
        end
        last = pc_out;
        cycle(0, 1, 0, 0, '0, 0, '0, 1);
        vectors++;
        if (pc_out !== last + 32'd4 || flush_out !== 1'b0 || ras_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL ras_empty_ret: pc=%h flush=%b empty=%b, want pc=%h 0 1",
                     pc_out, flush_out, ras_empty, last + 32'd4);
        end
    endtask

    task automatic test_back_to_back();
        cycle(0, 1, 0, 0, '0, 1, 32'hA0, 0);
        cycle(0, 1, 0, 0, '0, 1, 32'hB0, 1);
        vectors++;
        if (pc_out !== 32'hA0 || flush_out !== 1'b1 || ras_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL call_ret_same: pc=%h flush=%b empty=%b, want 000000a0 1 0",
                     pc_out, flush_out, ras_empty);
        end
        cycle(0, 0, 0, 0, '0, 1, 32'hC0, 1);
        vectors++;
        if (pc_out !== 32'hA0 || flush_out !== 1'b0) begin
            miscompares++;
            $display("FAIL stalled_ret: pc=%h flush=%b, want 000000a0 0", pc_out, flush_out);
        end
        cycle(0, 1, 0, 0, '0, 0, '0, 1);
        vectors++;
        if (pc_out !== 32'hB0 || ras_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL ret_after_replace: pc=%h empty=%b, want 000000b0 1", pc_out, ras_empty);
        end
    endtask

    task automatic test_wrap_and_reset();
        cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, '0, 0);
        idle(1);
        vectors++;
        if (pc_out !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_wrap: pc=%h, want 00000000", pc_out);
        end
        cycle(0, 1, 0, 0, '0, 1, 32'h77, 0);
        cycle(1, 1, 0, 1, 32'h400, 0, '0, 0);
        vectors++;
        if (pc_out !== RV || ras_empty !== 1'b1 || flush_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_over_redirect: pc=%h empty=%b flush=%b, want %h 1 0",
                     pc_out, ras_empty, flush_out, RV);
        end
    endtask

    task automatic test_random();
        bit r, we, tr, exv, call, ret;
        logic [31:0] tgt, link;
        for (int n = 0; n < 400; n++) begin
            r    = ($urandom_range(0, 49) == 0);
            we   = ($urandom_range(0, 3) != 0);
            tr   = ($urandom_range(0, 19) == 0);
            exv  = ($urandom_range(0, 9) == 0);
            tgt  = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 2) != 0) tgt[1:0] = 2'b00;
            call = ($urandom_range(0, 2) == 0);
            ret  = ($urandom_range(0, 2) == 0);
            link = $urandom & 32'h0000_FFFC;
            cycle(r, we, tr, exv, tgt, call, link, ret);
            vectors++;
            if ({pc_out, flush_out, misaligned_out, ras_empty} !==
                {m_pc, m_flush, m_mis, m_ras.size() == 0}) begin
                miscompares++;
                $display("FAIL random[%0d]: pc=%h flush=%b mis=%b empty=%b, want pc=%h %b %b %b",
                         n, pc_out, flush_out, misaligned_out, ras_empty,
                         m_pc, m_flush, m_mis, m_ras.size() == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_trap_priority();
        test_misaligned();
        cycle(1, 0, 0, 0, '0, 0, '0, 0);
        test_ras();
        test_back_to_back();
        test_wrap_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
